// File: rtl/i2c_pwm_gpio_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gpio_pkg
// Description : Shared register addresses, channel mode encoding and CTRL
//               bit positions for the i2c_pwm_gpio_bank peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_gpio_pkg;

  // Global register addresses
  localparam logic [7:0] ADDR_GCTRL   = 8'h00;
  localparam logic [7:0] ADDR_PRESC   = 8'h01;
  localparam logic [7:0] ADDR_PIN_IN  = 8'h02;
  localparam logic [7:0] ADDR_ID      = 8'h03;
  localparam logic [7:0] ADDR_CH_BASE = 8'h10;

  // Upper nibble of the ID register
  localparam logic [3:0] ID_TAG = 4'hA;

  // Channel output mode
  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SIGMA  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // CTRL register bit positions
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_LEVEL    = 2;
  localparam int CTRL_OE       = 3;
  localparam int CTRL_INV      = 4;
  localparam int CTRL_W        = 5;

  // Address of CTRL[c]; DUTY[c] sits at the next address
  function automatic logic [7:0] ctrl_addr(input int c);
    return ADDR_CH_BASE + 8'(2 * c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_pwm_gpio_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pwm_gpio_bank_if
// Description : Application-side register bus of the i2c_slave
//               (addr / wen / wdata / rdata).
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_pwm_gpio_bank_if;
  logic [7:0] addr;
  logic       wen;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output addr, output wen, output wdata, input rdata);
  modport slave  (input addr, input wen, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/i2c_pwm_gpio_bank_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One GPIO/PWM channel: CTRL/DUTY registers, shadow duty,
//               sigma-delta accumulator and registered pin outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
  import pwm_gpio_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              wrap_i,
  input  logic [PWM_W-1:0]  cnt_i,
  input  logic              wr_ctrl_i,
  input  logic              wr_duty_i,
  input  logic [7:0]        wdata_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [7:0]        duty_o,
  output logic              pin_o,
  output logic              pin_oe_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [7:0]        duty_q;
  logic [PWM_W-1:0]  shadow_q;
  logic [PWM_W-1:0]  acc_q;
  logic [PWM_W-1:0]  acc_d;
  logic [PWM_W-1:0]  acc_sum;
  logic              acc_carry;
  logic              mode_change;
  logic              out_d;
  logic              pin_q;
  logic              oe_q;
  mode_e             mode;

  assign mode        = mode_e'(ctrl_q[CTRL_MODE_LSB +: 2]);
  assign mode_change = wr_ctrl_i && (wdata_i[CTRL_MODE_LSB +: 2] != ctrl_q[CTRL_MODE_LSB +: 2]);

  // Software-visible CTRL and DUTY registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      duty_q <= '0;
    end else begin
      if (wr_ctrl_i) ctrl_q <= wdata_i[CTRL_W-1:0];
      if (wr_duty_i) duty_q <= wdata_i;
    end
  end

  // Shadow duty follows DUTY while disabled, so the first enabled period
  // already uses it; while running it only reloads at the counter wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (!en_i || wrap_i) begin
      shadow_q <= duty_q[PWM_W-1:0];
    end
  end

  // Sigma-delta accumulator next state: cleared when disabled or on a mode change
  always_comb begin
    {acc_carry, acc_sum} = {1'b0, acc_q} + {1'b0, duty_q[PWM_W-1:0]};
    acc_d = acc_q;
    if (!en_i || mode_change) begin
      acc_d = '0;
    end else if (mode == MODE_SIGMA) begin
      acc_d = acc_sum;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // Raw channel output before inversion; reserved mode falls back to static
  always_comb begin
    out_d = ctrl_q[CTRL_LEVEL];
    case (mode)
      MODE_SIGMA: out_d = en_i && acc_carry;
      MODE_PWM:   out_d = en_i && (cnt_i < shadow_q);
      default:    out_d = ctrl_q[CTRL_LEVEL];
    endcase
  end

  // Registered pad drive and enable
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_q <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      pin_q <= out_d ^ ctrl_q[CTRL_INV];
      oe_q  <= ctrl_q[CTRL_OE];
    end
  end

  assign ctrl_o   = ctrl_q;
  assign duty_o   = duty_q;
  assign pin_o    = pin_q;
  assign pin_oe_o = oe_q;

endmodule
`default_nettype wire

// File: rtl/i2c_pwm_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pwm_gpio_bank
// Description : NUM_CH-channel GPIO/PWM bank behind the i2c_slave register
//               bus. Holds global control, shared prescaler/counter, pin
//               input synchroniser and the read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_pwm_gpio_bank
  import pwm_gpio_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PWM_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  i2c_pwm_gpio_bank_if.slave bus,
  input  logic [NUM_CH-1:0]  pin_i,
  output logic [NUM_CH-1:0]  pin_o,
  output logic [NUM_CH-1:0]  pin_oe
);

  localparam logic [PWM_W-1:0] CNT_ONE = PWM_W'(1);

  logic              en_q;
  logic [7:0]        presc_q;
  logic [7:0]        pre_q;
  logic [PWM_W-1:0]  cnt_q;
  logic              tick;
  logic              wrap;
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [7:0]        rdata_d;
  logic [CTRL_W-1:0] ch_ctrl [NUM_CH];
  logic [7:0]        ch_duty [NUM_CH];

  // Global registers: GCTRL.EN and PRESC
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      presc_q <= '0;
    end else if (bus.wen) begin
      if (bus.addr == ADDR_GCTRL) en_q    <= bus.wdata[0];
      if (bus.addr == ADDR_PRESC) presc_q <= bus.wdata;
    end
  end

  // Equality compare: if PRESC drops below pre, pre wraps through 255 first
  assign tick = en_q && (pre_q == presc_q);
  assign wrap = tick && (cnt_q == '1);

  // Shared prescaler and PWM counter, held at zero while disabled
  always_ff @(posedge clk) begin
    if (rst || !en_q) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
      cnt_q <= cnt_q + CNT_ONE;
    end else begin
      pre_q <= pre_q + 8'd1;
    end
  end

  // Two-flop synchroniser for the pad inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_channel #(
      .PWM_W (PWM_W)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en_q),
      .wrap_i    (wrap),
      .cnt_i     (cnt_q),
      .wr_ctrl_i (bus.wen && (bus.addr == ctrl_addr(c))),
      .wr_duty_i (bus.wen && (bus.addr == (ctrl_addr(c) + 8'd1))),
      .wdata_i   (bus.wdata),
      .ctrl_o    (ch_ctrl[c]),
      .duty_o    (ch_duty[c]),
      .pin_o     (pin_o[c]),
      .pin_oe_o  (pin_oe[c])
    );
  end

  // Combinational read mux; unmapped addresses read zero
  always_comb begin
    rdata_d = 8'h00;
    case (bus.addr)
      ADDR_GCTRL:  rdata_d = {7'd0, en_q};
      ADDR_PRESC:  rdata_d = presc_q;
      ADDR_PIN_IN: rdata_d = 8'(sync2_q);
      ADDR_ID:     rdata_d = {ID_TAG, 4'(NUM_CH)};
      default:     rdata_d = 8'h00;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.addr == ctrl_addr(c))          rdata_d = 8'(ch_ctrl[c]);
      if (bus.addr == (ctrl_addr(c) + 8'd1)) rdata_d = ch_duty[c];
    end
  end

  assign bus.rdata = rdata_d;

endmodule
`default_nettype wire

// File: tb/tb_i2c_pwm_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_pwm_gpio_bank
// Description : Directed self-checking bench for i2c_pwm_gpio_bank
//               (NUM_CH=4, PWM_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_pwm_gpio_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pin_i = 4'h0;
  logic [3:0] pin_o;
  logic [3:0] pin_oe;
  int         n_checks = 0;
  int         n_fail   = 0;

  i2c_pwm_gpio_bank_if bus ();

  i2c_pwm_gpio_bank #(
    .NUM_CH (4),
    .PWM_W  (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pin_i  (pin_i),
    .pin_o  (pin_o),
    .pin_oe (pin_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.wen   = 1'b1;
    @(negedge clk);
    bus.wen   = 1'b0;
    bus.wdata = 8'h00;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.addr = a;
    #1;
    check_eq(tag, {24'd0, bus.rdata}, {24'd0, exp});
  endtask

  // Wait for a rising edge on pin_o[1], bounded
  task automatic align_rise(input string tag);
    logic prev;
    logic ok;
    ok   = 1'b0;
    prev = pin_o[1];
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prev == 1'b0 && pin_o[1] == 1'b1) begin
        ok = 1'b1;
        break;
      end
      prev = pin_o[1];
    end
    check_eq(tag, {31'd0, ok}, 32'd1);
  endtask

  // Length of the current run of value v on pin_o[1], starting from 'start' samples
  task automatic run_len(input logic v, input int start, output int n);
    n = start;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pin_o[1] !== v) break;
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.addr  = 8'h00;
    bus.wen   = 1'b0;
    bus.wdata = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_pin_o", {28'd0, pin_o}, 32'h0);
    check_eq("rst_pin_oe", {28'd0, pin_oe}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    read_check("id", 8'h03, 8'hA4);
    read_check("pin_in_rst", 8'h02, 8'h00);
    read_check("gctrl_rst", 8'h00, 8'h00);
    read_check("unmapped", 8'h18, 8'h00);

    // PIN_IN two-clock latency
    pin_i = 4'hA;
    @(negedge clk);
    read_check("pin_in_1clk", 8'h02, 8'h00);
    @(negedge clk);
    read_check("pin_in_2clk", 8'h02, 8'h0A);
    pin_i = 4'h0;

    // Static level, output registers add one cycle after the write edge
    bus_write(8'h10, 8'h0C);
    check_eq("static_n", {31'd0, pin_o[0]}, 32'd0);
    read_check("ctrl0_rb", 8'h10, 8'h0C);
    @(negedge clk);
    check_eq("static_pin", {31'd0, pin_o[0]}, 32'd1);
    check_eq("static_oe", {31'd0, pin_oe[0]}, 32'd1);
    bus_write(8'h10, 8'h1C);
    @(negedge clk);
    check_eq("static_inv", {31'd0, pin_o[0]}, 32'd0);

    // Reserved mode acts as static; upper CTRL bits read zero
    bus_write(8'h16, 8'hFF);
    read_check("ctrl3_rb", 8'h16, 8'h1F);
    @(negedge clk);
    check_eq("rsvd_inv_pin", {31'd0, pin_o[3]}, 32'd0);
    check_eq("rsvd_oe", {31'd0, pin_oe[3]}, 32'd1);
    bus_write(8'h16, 8'h07);
    @(negedge clk);
    check_eq("rsvd_pin", {31'd0, pin_o[3]}, 32'd1);
    check_eq("rsvd_oe_off", {31'd0, pin_oe[3]}, 32'd0);

    // PWM, PRESC=0, duty 64 of 256
    bus_write(8'h00, 8'h01);
    bus_write(8'h01, 8'h00);
    bus_write(8'h13, 8'd64);
    bus_write(8'h12, 8'h0A);
    read_check("duty1_rb", 8'h13, 8'd64);
    align_rise("pwm_align");
    run_len(1'b1, 1, n); check_eq("pwm64_high", n, 64);
    run_len(1'b0, 1, n); check_eq("pwm64_low", n, 192);
    run_len(1'b1, 1, n); check_eq("pwm64_high2", n, 64);

    // Mid-period duty update takes effect at the next period only
    bus_write(8'h13, 8'd192);
    run_len(1'b0, 3, n); check_eq("upd_low_cur", n, 192);
    run_len(1'b1, 1, n); check_eq("upd_high_next", n, 192);
    run_len(1'b0, 1, n); check_eq("upd_low_next", n, 64);

    // PRESC=1 doubles every count
    bus_write(8'h01, 8'h01);
    align_rise("presc_align");
    run_len(1'b1, 1, n); check_eq("presc_high", n, 384);
    run_len(1'b0, 1, n); check_eq("presc_low", n, 128);

    // Sigma-delta with DUTY=0x80 toggles every clock, starting low
    bus_write(8'h15, 8'h80);
    bus_write(8'h14, 8'h09);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("sigma_%0d", i), {31'd0, pin_o[2]}, i % 2);
    end

    // EN=0 forces SIGMA/PWM low, static channels unaffected
    bus_write(8'h00, 8'h00);
    @(negedge clk);
    check_eq("dis_sigma", {31'd0, pin_o[2]}, 32'd0);
    check_eq("dis_pwm", {31'd0, pin_o[1]}, 32'd0);
    check_eq("dis_static", {31'd0, pin_o[3]}, 32'd1);
    @(negedge clk);
    check_eq("dis_sigma2", {31'd0, pin_o[2]}, 32'd0);
    bus_write(8'h14, 8'h19);
    @(negedge clk);
    check_eq("dis_sigma_inv", {31'd0, pin_o[2]}, 32'd1);

    // Reset in the middle of a PWM high phase
    bus_write(8'h00, 8'h01);
    bus_write(8'h10, 8'h0C);
    align_rise("rst_align");
    repeat (10) @(negedge clk);
    check_eq("pre_rst_high", {31'd0, pin_o[1]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_pin_o", {28'd0, pin_o}, 32'h0);
    check_eq("mid_rst_pin_oe", {28'd0, pin_oe}, 32'h0);
    rst = 1'b0;
    read_check("mid_rst_gctrl", 8'h00, 8'h00);
    read_check("mid_rst_presc", 8'h01, 8'h00);
    read_check("mid_rst_ctrl0", 8'h10, 8'h00);
    read_check("mid_rst_ctrl1", 8'h12, 8'h00);
    read_check("mid_rst_duty1", 8'h13, 8'h00);
    repeat (300) @(negedge clk);
    check_eq("no_residual", {28'd0, pin_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
